// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type and an alignment helper used at request accept.
// ---------------------------------------------------------------------------
package mem_access_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // True when the size code is illegal or the byte offset does not match
  // the natural alignment of the access.
  function automatic logic bad_size_or_align(input logic [1:0] size,
                                             input logic [1:0] off);
    case (size)
      SIZE_B:  bad_size_or_align = 1'b0;
      SIZE_H:  bad_size_or_align = off[0];
      SIZE_W:  bad_size_or_align = |off;
      SIZE_X:  bad_size_or_align = 1'b1;
      default: bad_size_or_align = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational little-endian lane steering for 32-bit word memory.
//   byte_off      : byte offset within the word (addr[1:0])
//   size          : SIZE_B / SIZE_H / SIZE_W
//   lane_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   word_in       : word as read from RAM
//   store_data    : right-aligned store data
//   load_data     : selected lane, extended to 32 bits
//   merged_word   : word_in with the addressed lane(s) replaced by store_data
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        lane_unsigned,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    load_data   = '0;
    merged_word = word_in;
    lane_b      = word_in[{byte_off, 3'b000} +: 8];
    lane_h      = byte_off[1] ? word_in[31:16] : word_in[15:0];
    case (size)
      SIZE_B: begin
        load_data = {{24{~lane_unsigned & lane_b[7]}}, lane_b};
        merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      end
      SIZE_H: begin
        load_data = {{16{~lane_unsigned & lane_h[15]}}, lane_h};
        merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
      end
      SIZE_W: begin
        load_data   = word_in;
        merged_word = store_data;
      end
      default: begin
        load_data   = '0;
        merged_word = word_in;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between the core memory stage and a 32-bit word RAM.
// Byte-addressed requests arrive over valid/ready; sub-word loads are
// extracted and extended, sub-word stores are done as read-modify-write.
//   clk, reset                : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/addr/size/unsigned/wdata : request fields
//   rsp_valid/rsp_rdata/rsp_error   : one-cycle response pulse
//   address/write_data/MemWrite/MemRead/read_data : RAM port
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; accept and classify a request
// READ  | RAM word read, MemRead high, word captured at cycle end
// WRITE | MemWrite high with the merged (or full) word
// RESP  | rsp_valid pulse with rdata / error
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter  int profundidad = 1024,
  localparam int AW          = $clog2(profundidad)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] address,
  output logic [31:0]   write_data,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [31:0]   read_data
);

  localparam logic [31:0] PROF_W = 32'(profundidad);

  state_t      state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        mem_write_q;

  logic [29:0]   req_word_idx;
  logic [AW-1:0] req_word;
  logic          req_err;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;

  assign req_word_idx = req_addr[31:2];
  assign req_word     = req_addr[AW+1:2];
  assign req_err      = bad_size_or_align(req_size, req_addr[1:0]) ||
                        ({2'b00, req_word_idx} >= PROF_W);

  // Ready is a pure state decode, held low for the whole reset cycle so no
  // request can be considered accepted while the unit is being cleared.
  assign req_ready = (state == IDLE) && !reset;

  // A reset arriving in WRITE must not corrupt RAM, so the strobe is gated
  // combinationally rather than waiting for the register to clear.
  assign MemWrite = mem_write_q && !reset;

  // Lane steering works on the live RAM word during READ; the resulting
  // merged word is captured into write_data at the end of READ, which is
  // the word register feeding the WRITE cycle.
  mem_lane_align u_align (
    .byte_off      (off_q),
    .size          (size_q),
    .lane_unsigned (uns_q),
    .word_in       (read_data),
    .store_data    (wdata_q),
    .load_data     (load_data),
    .merged_word   (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      off_q       <= '0;
      size_q      <= SIZE_B;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      address     <= '0;
      write_data  <= '0;
      mem_write_q <= 1'b0;
      MemRead     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && (req_size == SIZE_W)) begin
              state       <= WRITE;
              address     <= req_word;
              write_data  <= req_wdata;
              mem_write_q <= 1'b1;
            end else begin
              state   <= READ;
              address <= req_word;
              MemRead <= 1'b1;
            end
          end
        end

        READ: begin
          MemRead <= 1'b0;
          if (we_q) begin
            state       <= WRITE;
            write_data  <= merged_word;
            mem_write_q <= 1'b1;
          end else begin
            state     <= RESP;
            address   <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_error <= 1'b0;
          end
        end

        WRITE: begin
          state       <= RESP;
          address     <= '0;
          write_data  <= '0;
          mem_write_q <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_error   <= 1'b0;
        end

        RESP: begin
          state     <= IDLE;
          rsp_rdata <= '0;
          rsp_error <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
